cpu_bus_bridge: RTL and testbench
=================================

Name: cpu_bus_bridge

Overview:
- Downstream partner of the CPU external bus port.
- Consumes the CPU's four-phase request: bus clock, write enable, address and write data. Returns read data and data-ready.
- Routes each access either to an asynchronous external SRAM, using programmable wait states, or to an 8-bit-addressed I/O peripheral port with an ack timeout.
- Sits between the CPU core and board-level memory/peripherals in the top level.

Parameters:
- ADDR_W, 32, CPU bus address width.
- DATA_W, 32, CPU bus data width.
- MEM_AW, 19, external SRAM address width; low bits of CPU address.
- RD_WAIT, 2, extra SRAM read-strobe cycles (0..15).
- WR_WAIT, 2, extra SRAM write-strobe cycles (0..15).
- IO_BASE, 32'hFFFF_FF00, I/O region base; region is 256 bytes, matched on address[ADDR_W-1:8].
- IO_TIMEOUT, 255, cycles to wait for i_io_ack before forcing completion.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_bus_clk  in  1  CPU request strobe (the CPU's bus clock output)
- i_bus_we  in  1  1=write, 0=read
- i_bus_addr  in  ADDR_W  access address
- i_bus_data  in  DATA_W  write data
- o_bus_data  out  DATA_W  read data to CPU
- o_bus_data_ready  out  1  completion handshake to CPU
- o_mem_addr  out  MEM_AW  SRAM address
- o_mem_wdata  out  DATA_W  SRAM write data
- i_mem_rdata  in  DATA_W  SRAM read data
- o_mem_ce_n  out  1  SRAM chip enable, active low
- o_mem_oe_n  out  1  SRAM output enable, active low
- o_mem_we_n  out  1  SRAM write enable, active low
- o_io_req  out  1  I/O request, level
- o_io_we  out  1  I/O write
- o_io_addr  out  8  I/O register offset
- o_io_wdata  out  DATA_W  I/O write data
- i_io_rdata  in  DATA_W  I/O read data
- i_io_ack  in  1  I/O completion
- o_io_timeout  out  1  one-cycle pulse when an I/O access times out

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE;
  - o_bus_data=0, o_bus_data_ready=0;
  - o_mem_ce_n=o_mem_oe_n=o_mem_we_n=1, o_mem_addr=0, o_mem_wdata=0;
  - o_io_req=0, o_io_we=0, o_io_addr=0, o_io_wdata=0, o_io_timeout=0.
  - Reset mid-access releases all strobes immediately and abandons the access.
- Handshake: the CPU raises i_bus_clk with address, we and data stable. The bridge raises o_bus_data_ready when complete. The CPU drops i_bus_clk. The bridge drops ready on the first edge where it samples i_bus_clk=0.
- States: IDLE, MEM_SETUP, MEM_ACCESS, IO_WAIT, DONE.
- IDLE: on an edge with i_bus_clk=1, latch we/addr/data. Decode: addr[ADDR_W-1:8]==IO_BASE[ADDR_W-1:8] goes to IO_WAIT; otherwise to MEM_SETUP.
- MEM_SETUP, 1 cycle:
  - ce_n=0, oe_n=we_n=1;
  - o_mem_addr=addr[MEM_AW-1:0], higher bits discarded;
  - wdata driven.
  - Next state MEM_ACCESS; wait counter loaded with RD_WAIT or WR_WAIT.
- MEM_ACCESS: ce_n=0, plus oe_n=0 (read) or we_n=0 (write).
  - Each edge: if counter==0, set ready=1, capture i_mem_rdata into o_bus_data on reads only, deassert ce_n/oe_n/we_n, go DONE.
  - Otherwise decrement the counter.
- Memory latency: ready rises at edge N+2+WAIT, where N is the IDLE edge that sampled the request. WAIT=0 gives N+2.
- IO_WAIT: o_io_req=1 with we/addr[7:0]/wdata held; timeout counter starts at 0.
  - On an edge with i_io_ack=1: drop req; capture i_io_rdata on reads; set ready; go DONE.
  - Otherwise, when the counter reaches IO_TIMEOUT: drop req; o_bus_data=all-ones on reads; pulse o_io_timeout for one cycle; set ready; go DONE.
  - If ack and timeout occur on the same edge, ack wins and there is no timeout pulse.
- DONE: ready held at 1. On an edge with i_bus_clk=0: ready=0, go IDLE. A new request is accepted no earlier than the following edge, so back-to-back accesses have at least one idle cycle.
- o_bus_data holds the last read value. Writes never modify it.
- Inputs changing while not in IDLE are ignored; all access parameters are latched.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - the state enum (IDLE, MEM_SETUP, MEM_ACCESS, IO_WAIT, DONE);
  - the IO region width constant (8);
  - the timeout fill value (all-ones).
- One sub-module, bus_wait_counter: loadable down-counter with a zero flag.
  - Used for SRAM wait states.
  - A second instance, in up mode with compare, is used for the I/O timeout.

Test Plan:
- Reset asserted mid MEM_ACCESS (we_n=0) -> we_n, ce_n, ready return to 1/1/0 with no clock edge; next request is serviced normally.
- Read addr 32'h0001_2345, RD_WAIT=2, i_mem_rdata=32'hDEAD_BEEF -> o_mem_addr=19'h12345; oe_n low exactly 3 cycles; ready at N+4; o_bus_data=DEADBEEF; ready drops the edge after i_bus_clk falls.
- Write addr 32'h0000_0010, data 32'h1234_5678, WR_WAIT=0 -> we_n low 1 cycle; o_mem_wdata=12345678; ready at N+2; o_bus_data unchanged.
- I/O read 32'hFFFF_FF04, ack after 5 cycles with rdata 32'h0000_00A5 -> o_io_addr=8'h04; io_req high 5 cycles; o_bus_data=A5; no timeout pulse.
- I/O read with no ack -> io_req drops after IO_TIMEOUT cycles; o_bus_data=FFFFFFFF; o_io_timeout single pulse; ready=1.
- Back-to-back: CPU re-raises i_bus_clk one cycle after ready drops -> second access latches new address; no strobe overlap between the two accesses.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types and constants for the CPU bus bridge
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_SETUP,
    ST_MEM_ACCESS,
    ST_IO_WAIT,
    ST_DONE
  } bus_state_t;

  // Low address bits that select an I/O register inside the I/O region
  localparam int IO_REGION_W = 8;

  localparam int CNT_W = 8;

  // Read data returned when an I/O access times out
  localparam logic [63:0] TIMEOUT_FILL = '1;

endpackage

// File: rtl/bus_wait_counter.sv
// rtl/bus_wait_counter.sv - loadable up/down counter with zero or compare hit flag
module bus_wait_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  input  logic [W-1:0] i_cmp_val,
  output logic         o_hit
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= i_up ? r_count + 1'b1 : r_count - 1'b1;
    end
  end

  // Down mode flags zero; up mode flags reaching the compare value
  assign o_hit = i_up ? (r_count == i_cmp_val) : (r_count == '0);

endmodule

// File: rtl/cpu_bus_bridge.sv
// rtl/cpu_bus_bridge.sv - CPU bus bridge to async SRAM (wait states) and I/O port (ack timeout)
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                MEM_AW     = 19,
  parameter int                RD_WAIT    = 2,
  parameter int                WR_WAIT    = 2,
  parameter logic [ADDR_W-1:0] IO_BASE    = 32'hFFFF_FF00,
  parameter int                IO_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bus_clk,
  input  logic              i_bus_we,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic [DATA_W-1:0] i_bus_data,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_data_ready,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_mem_ce_n,
  output logic              o_mem_oe_n,
  output logic              o_mem_we_n,
  output logic              o_io_req,
  output logic              o_io_we,
  output logic [7:0]        o_io_addr,
  output logic [DATA_W-1:0] o_io_wdata,
  input  logic [DATA_W-1:0] i_io_rdata,
  input  logic              i_io_ack,
  output logic              o_io_timeout
);

  localparam logic [DATA_W-1:0] FILL_VAL = TIMEOUT_FILL[DATA_W-1:0];
  localparam logic [CNT_W-1:0]  RD_LOAD  = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0]  WR_LOAD  = CNT_W'(WR_WAIT);
  // Counter value seen on the edge that is IO_TIMEOUT cycles after the request
  localparam logic [CNT_W-1:0]  IO_CMP   = (IO_TIMEOUT > 0) ? CNT_W'(IO_TIMEOUT - 1) : '0;

  bus_state_t r_state, w_next_state;

  logic              r_we;
  logic [DATA_W-1:0] r_bus_data;
  logic              r_ready;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_ce_n, r_mem_oe_n, r_mem_we_n;
  logic              r_io_req, r_io_we, r_io_timeout;
  logic [7:0]        r_io_addr;
  logic [DATA_W-1:0] r_io_wdata;

  logic w_is_io;
  logic w_mem_load, w_mem_en, w_mem_hit;
  logic w_io_load, w_io_en, w_io_hit;

  assign w_is_io = (i_bus_addr[ADDR_W-1:IO_REGION_W] == IO_BASE[ADDR_W-1:IO_REGION_W]);

  bus_wait_counter #(.W(CNT_W)) u_mem_wait (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_mem_load),
    .i_load_val (r_we ? WR_LOAD : RD_LOAD),
    .i_en       (w_mem_en),
    .i_up       (1'b0),
    .i_cmp_val  ('0),
    .o_hit      (w_mem_hit)
  );

  bus_wait_counter #(.W(CNT_W)) u_io_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_io_load),
    .i_load_val ('0),
    .i_en       (w_io_en),
    .i_up       (1'b1),
    .i_cmp_val  (IO_CMP),
    .o_hit      (w_io_hit)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_load   = 1'b0;
    w_mem_en     = 1'b0;
    w_io_load    = 1'b0;
    w_io_en      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_bus_clk) begin
          w_next_state = w_is_io ? ST_IO_WAIT : ST_MEM_SETUP;
          w_io_load    = w_is_io;
        end
      end
      ST_MEM_SETUP: begin
        w_next_state = ST_MEM_ACCESS;
        w_mem_load   = 1'b1;
      end
      ST_MEM_ACCESS: begin
        if (w_mem_hit) w_next_state = ST_DONE;
        else           w_mem_en     = 1'b1;
      end
      ST_IO_WAIT: begin
        if (i_io_ack || w_io_hit) w_next_state = ST_DONE;
        else                      w_io_en      = 1'b1;
      end
      ST_DONE: begin
        if (!i_bus_clk) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we         <= 1'b0;
      r_bus_data   <= '0;
      r_ready      <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_ce_n   <= 1'b1;
      r_mem_oe_n   <= 1'b1;
      r_mem_we_n   <= 1'b1;
      r_io_req     <= 1'b0;
      r_io_we      <= 1'b0;
      r_io_addr    <= '0;
      r_io_wdata   <= '0;
      r_io_timeout <= 1'b0;
    end else begin
      r_io_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_bus_clk) begin
            r_we <= i_bus_we;
            if (w_is_io) begin
              r_io_req   <= 1'b1;
              r_io_we    <= i_bus_we;
              r_io_addr  <= i_bus_addr[IO_REGION_W-1:0];
              r_io_wdata <= i_bus_data;
            end else begin
              r_mem_ce_n  <= 1'b0;
              r_mem_addr  <= i_bus_addr[MEM_AW-1:0];
              r_mem_wdata <= i_bus_data;
            end
          end
        end
        ST_MEM_SETUP: begin
          if (r_we) r_mem_we_n <= 1'b0;
          else      r_mem_oe_n <= 1'b0;
        end
        ST_MEM_ACCESS: begin
          if (w_mem_hit) begin
            r_ready    <= 1'b1;
            r_mem_ce_n <= 1'b1;
            r_mem_oe_n <= 1'b1;
            r_mem_we_n <= 1'b1;
            if (!r_we) r_bus_data <= i_mem_rdata;
          end
        end
        ST_IO_WAIT: begin
          // A late ack on the timeout edge still completes normally
          if (i_io_ack) begin
            r_io_req <= 1'b0;
            r_ready  <= 1'b1;
            if (!r_io_we) r_bus_data <= i_io_rdata;
          end else if (w_io_hit) begin
            r_io_req     <= 1'b0;
            r_ready      <= 1'b1;
            r_io_timeout <= 1'b1;
            if (!r_io_we) r_bus_data <= FILL_VAL;
          end
        end
        ST_DONE: begin
          if (!i_bus_clk) r_ready <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_bus_data       = r_bus_data;
  assign o_bus_data_ready = r_ready;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_wdata      = r_mem_wdata;
  assign o_mem_ce_n       = r_mem_ce_n;
  assign o_mem_oe_n       = r_mem_oe_n;
  assign o_mem_we_n       = r_mem_we_n;
  assign o_io_req         = r_io_req;
  assign o_io_we          = r_io_we;
  assign o_io_addr        = r_io_addr;
  assign o_io_wdata       = r_io_wdata;
  assign o_io_timeout     = r_io_timeout;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb/tb_cpu_bus_bridge.sv - directed self-checking bench for cpu_bus_bridge
module tb_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_clk, bus_we;
  logic [31:0] bus_addr, bus_data;
  logic [31:0] o_bus_data;
  logic        o_ready;
  logic [18:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        ce_n, oe_n, we_n;
  logic        io_req, io_we;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        io_ack, io_to;

  int n_tests = 0;
  int n_fail  = 0;
  int lat, oe_cnt, we_cnt, req_cnt, to_cnt, ovl_cnt;
  logic [1:0] first_strobes;
  logic       ready_after;

  always #5 clk = ~clk;

  cpu_bus_bridge #(.RD_WAIT(2), .WR_WAIT(0), .IO_TIMEOUT(255)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_bus_clk        (bus_clk),
    .i_bus_we         (bus_we),
    .i_bus_addr       (bus_addr),
    .i_bus_data       (bus_data),
    .o_bus_data       (o_bus_data),
    .o_bus_data_ready (o_ready),
    .o_mem_addr       (mem_addr),
    .o_mem_wdata      (mem_wdata),
    .i_mem_rdata      (mem_rdata),
    .o_mem_ce_n       (ce_n),
    .o_mem_oe_n       (oe_n),
    .o_mem_we_n       (we_n),
    .o_io_req         (io_req),
    .o_io_we          (io_we),
    .o_io_addr        (io_addr),
    .o_io_wdata       (io_wdata),
    .i_io_rdata       (io_rdata),
    .i_io_ack         (io_ack),
    .o_io_timeout     (io_to)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full four-phase access; lat==k+1 means ready rose on edge N+k
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input int ack_after);
    @(negedge clk);
    bus_clk = 1'b1; bus_we = we; bus_addr = addr; bus_data = data;
    lat = 0; oe_cnt = 0; we_cnt = 0; req_cnt = 0; to_cnt = 0; ovl_cnt = 0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) first_strobes = {oe_n, we_n};
      if (!oe_n) oe_cnt++;
      if (!we_n) we_cnt++;
      if (io_req) req_cnt++;
      if (io_to) to_cnt++;
      if (!ce_n && io_req) ovl_cnt++;
      if (lat == 2) begin
        bus_addr = ~addr; bus_data = ~data; bus_we = ~we;
      end
      if (ack_after > 0 && lat == ack_after) io_ack = 1'b1;
      if (o_ready) break;
    end
    io_ack = 1'b0;
    chk("ready_seen", {31'd0, o_ready}, 32'd1);
    @(negedge clk);
    bus_clk = 1'b0;
    @(posedge clk); #1;
    if (io_to) to_cnt++;
    ready_after = o_ready;
  endtask

  initial begin
    rst = 1'b1;
    bus_clk = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_data = '0;
    mem_rdata = 32'hDEAD_BEEF; io_rdata = 32'h0000_00A5; io_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'd7);
    chk("rst_io", {22'd0, io_req, io_we, io_to, io_addr}, 32'd0);
    chk("rst_bus_data", o_bus_data, 32'd0);
    chk("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // SRAM read, 2 wait states
    access(1'b0, 32'h0001_2345, 32'h0, 0);
    chk("rd_lat", lat, 5);
    chk("rd_oe_cycles", oe_cnt, 3);
    chk("rd_mem_addr", {13'd0, mem_addr}, 32'h0001_2345);
    chk("rd_data", o_bus_data, 32'hDEAD_BEEF);
    chk("rd_ready_drop", {31'd0, ready_after}, 32'd0);

    // SRAM write, 0 wait states
    access(1'b1, 32'h0000_0010, 32'h1234_5678, 0);
    chk("wr_lat", lat, 3);
    chk("wr_we_cycles", we_cnt, 1);
    chk("wr_oe_cycles", oe_cnt, 0);
    chk("wr_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_bus_data_kept", o_bus_data, 32'hDEAD_BEEF);

    // I/O read acked after 5 cycles
    access(1'b0, 32'hFFFF_FF04, 32'h0, 5);
    chk("io_lat", lat, 6);
    chk("io_addr", {24'd0, io_addr}, 32'h04);
    chk("io_req_cycles", req_cnt, 5);
    chk("io_data", o_bus_data, 32'h0000_00A5);
    chk("io_no_timeout", to_cnt, 0);

    // I/O read never acked
    access(1'b0, 32'hFFFF_FF08, 32'h0, 0);
    chk("to_lat", lat, 256);
    chk("to_req_cycles", req_cnt, 255);
    chk("to_data", o_bus_data, 32'hFFFF_FFFF);
    chk("to_pulse_count", to_cnt, 1);

    // Ack lands on the timeout edge
    io_rdata = 32'h0000_005A;
    access(1'b0, 32'hFFFF_FF0C, 32'h0, 255);
    chk("race_lat", lat, 256);
    chk("race_data", o_bus_data, 32'h0000_005A);
    chk("race_no_pulse", to_cnt, 0);

    // Back-to-back accesses with upper address bits discarded
    access(1'b1, 32'h0000_0040, 32'hCAFE_0001, 0);
    access(1'b0, 32'hABC8_0001, 32'h0, 0);
    chk("b2b_lat", lat, 5);
    chk("b2b_mem_addr", {13'd0, mem_addr}, 32'h0000_0001);
    chk("b2b_setup_strobes", {30'd0, first_strobes}, 32'd3);
    access(1'b0, 32'hFFFF_FF10, 32'h0, 2);
    chk("b2b_io_addr", {24'd0, io_addr}, 32'h10);
    chk("b2b_no_overlap", ovl_cnt, 0);
    chk("b2b_io_lat", lat, 3);

    // Reset in the middle of an SRAM write strobe
    @(negedge clk);
    bus_clk = 1'b1; bus_we = 1'b1; bus_addr = 32'h0000_0020; bus_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_we_low", {31'd0, we_n}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'd7);
    chk("mid_rst_ready", {31'd0, o_ready}, 32'd0);
    bus_clk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 32'h0000_0100, 32'h0, 0);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_addr", {13'd0, mem_addr}, 32'h0000_0100);
    chk("post_rst_data", o_bus_data, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
